// File: rtl/common_pkg.sv
// Shared constants, the arbiter state type and small helpers for the
// credit-based NoC transmitter.
package common_pkg;

  localparam int DEFAULT_VC_W        = 2;
  localparam int DEFAULT_A_W         = 8;
  localparam int DEFAULT_D_W         = 32;
  localparam int DEFAULT_MAX_CREDITS = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..max_credits inclusive.
  function automatic int cnt_width(input int max_credits);
    return (max_credits < 1) ? 1 : $clog2(max_credits + 1);
  endfunction

  function automatic int onehot_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [31:0] vc_onehot(input int idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/noc_if.sv
// Credit-based link between a transmitter and a receiver: a one-hot VC target
// qualifies the packet, and the receiver returns one credit per VC bit.
interface noc_if #(
  parameter int VC_W = common_pkg::DEFAULT_VC_W,
  parameter int A_W  = common_pkg::DEFAULT_A_W,
  parameter int D_W  = common_pkg::DEFAULT_D_W
);

  typedef struct packed {
    logic [A_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
  } payload_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  logic [VC_W-1:0] credit_vc_target;
  packet_t         credit_packet;
  logic [VC_W-1:0] credit_vc_credit_gnt;

  modport transmitter (
    output credit_vc_target,
    output credit_packet,
    input  credit_vc_credit_gnt
  );

  modport receiver (
    input  credit_vc_target,
    input  credit_packet,
    output credit_vc_credit_gnt
  );

endinterface

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter: grants the first request at or above the stored
// pointer, wrapping; the pointer is reloaded only when ptr_upd_i is set.
module noc_rr_arb #(
  parameter  int VC_W  = 2,
  localparam int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VC_W-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             ptr_upd_i,
  output logic [VC_W-1:0]  gnt_o,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  assign ptr_d = ptr_upd_i ? ptr_i : ptr_q;
  assign ptr_o = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < VC_W; i++) begin
      idx = (int'(ptr_q) + i) % VC_W;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_credit_arb.sv
// Transmitter-side credit manager and VC arbiter: per-VC credit counters,
// packet lock FSM and a registered flit onto the link.
module noc_vc_credit_arb import common_pkg::*; #(
  parameter  int VC_W        = DEFAULT_VC_W,
  parameter  int A_W         = DEFAULT_A_W,
  parameter  int D_W         = DEFAULT_D_W,
  parameter  int MAX_CREDITS = DEFAULT_MAX_CREDITS,
  localparam int PTR_W       = (VC_W > 1) ? $clog2(VC_W) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VC_W-1:0]     req_valid,
  output logic [VC_W-1:0]     req_ready,
  input  logic [VC_W*A_W-1:0] req_addr,
  input  logic [VC_W*D_W-1:0] req_data,
  input  logic [VC_W-1:0]     req_last,
  noc_if.transmitter          to_rx,
  output logic                credit_err,
  output arb_state_e          dbg_state_o,
  output logic [PTR_W-1:0]    dbg_ptr_o
);

  localparam int              CNT_W   = cnt_width(MAX_CREDITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CREDITS);

  logic [CNT_W-1:0] cnt_q [VC_W];
  logic [CNT_W-1:0] cnt_d [VC_W];
  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] lock_q, lock_d;
  logic             err_q, err_d;
  logic [VC_W-1:0]  elig, grant, crd_ret, ovr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             ptr_upd, sel_last;
  int               sel_idx;
  logic [VC_W-1:0]  target_q;
  logic [A_W-1:0]   addr_q;
  logic [D_W-1:0]   data_q;
  logic             last_q;

  // Handshake: a flit moves on VC v in the cycle req_valid[v] & req_ready[v];
  // req_ready depends only on req_valid, credits, lock state and pointer.
  assign crd_ret = to_rx.credit_vc_credit_gnt;

  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = req_valid[v] && (cnt_q[v] != '0) &&
                ((state_q == ST_IDLE) || (lock_q == PTR_W'(v)));
    end
  end

  noc_rr_arb #(.VC_W(VC_W)) u_rr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (elig),
    .ptr_i     (ptr_nxt),
    .ptr_upd_i (ptr_upd),
    .gnt_o     (grant),
    .ptr_o     (dbg_ptr_o)
  );

  assign req_ready = grant & {VC_W{rst_n}};
  assign sel_idx   = onehot_idx(32'(req_ready));
  assign sel_last  = req_last[sel_idx];

  // A send and a return on the same VC cancel; an unmatched return at full
  // count is an upstream protocol error and the counter saturates.
  always_comb begin
    ovr = '0;
    for (int v = 0; v < VC_W; v++) begin
      cnt_d[v] = cnt_q[v];
      if (req_ready[v] && !crd_ret[v]) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
      end else if (!req_ready[v] && crd_ret[v]) begin
        if (cnt_q[v] == CNT_MAX) ovr[v] = 1'b1;
        else                     cnt_d[v] = cnt_q[v] + 1'b1;
      end
    end
    err_d = err_q | (|ovr);
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_upd = 1'b0;
    ptr_nxt = PTR_W'((sel_idx + 1) % VC_W);
    if (|req_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (sel_last) begin
            ptr_upd = 1'b1;
          end else begin
            state_d = ST_LOCKED;
            lock_d  = PTR_W'(sel_idx);
          end
        end
        ST_LOCKED: begin
          if (sel_last) begin
            state_d = ST_IDLE;
            ptr_upd = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_W; v++) cnt_q[v] <= CNT_MAX;
      state_q  <= ST_IDLE;
      lock_q   <= '0;
      err_q    <= 1'b0;
      target_q <= '0;
    end else begin
      for (int v = 0; v < VC_W; v++) cnt_q[v] <= cnt_d[v];
      state_q  <= state_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      target_q <= req_ready;
    end
  end

  // Payload is qualified by target_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (|req_ready) begin
      addr_q <= req_addr[sel_idx*A_W +: A_W];
      data_q <= req_data[sel_idx*D_W +: D_W];
      last_q <= sel_last;
    end
  end

  assign to_rx.credit_vc_target = target_q;
  assign to_rx.credit_packet    = {addr_q, data_q, last_q};
  assign credit_err             = err_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_noc_vc_credit_arb.sv
// Randomized bench for noc_vc_credit_arb against a per-VC credit/lock model
// with a link-side scoreboard.
module tb_noc_vc_credit_arb;
  import common_pkg::*;

  localparam int VC_W  = 3;
  localparam int A_W   = 8;
  localparam int D_W   = 16;
  localparam int MAXC  = 4;
  localparam int PTR_W = 2;
  localparam int W     = VC_W + A_W + D_W + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [VC_W-1:0]     req_valid, req_ready, req_last;
  logic [VC_W*A_W-1:0] req_addr;
  logic [VC_W*D_W-1:0] req_data;
  logic                credit_err;
  arb_state_e          dbg_state;
  logic [PTR_W-1:0]    dbg_ptr;

  noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) bus ();

  noc_vc_credit_arb #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .MAX_CREDITS(MAXC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_last    (req_last),
    .to_rx       (bus),
    .credit_err  (credit_err),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: credits available per VC, rotation start, packet lock.
  int m_cred[VC_W];
  int m_ptr;
  bit m_locked;
  int m_lock;
  bit m_err;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < VC_W; v++) m_cred[v] = MAXC;
    m_ptr    = 0;
    m_locked = 0;
    m_lock   = 0;
    m_err    = 0;
  endfunction

  // Returns only for credits actually outstanding.
  function automatic logic [VC_W-1:0] ret_auto(input int pct);
    logic [VC_W-1:0] r;
    r = '0;
    for (int v = 0; v < VC_W; v++) begin
      r[v] = (m_cred[v] < MAXC) && ($urandom_range(0, 99) < pct);
    end
    return r;
  endfunction

  task automatic drive_cycle(input logic [VC_W-1:0] vld, input logic [VC_W-1:0] lst,
                             input logic [VC_W-1:0] ret);
    int g;
    logic [VC_W-1:0] exp_rdy;
    logic [W-1:0]    entry;
    @(negedge clk);
    req_valid = vld;
    req_last  = lst;
    for (int v = 0; v < VC_W; v++) begin
      req_addr[v*A_W +: A_W] = A_W'($urandom);
      req_data[v*D_W +: D_W] = D_W'($urandom);
    end
    bus.credit_vc_credit_gnt = ret;
    #1;
    g = -1;
    for (int i = 0; i < VC_W; i++) begin
      int v;
      v = (m_ptr + i) % VC_W;
      if (g < 0 && vld[v] && m_cred[v] > 0 && (!m_locked || m_lock == v)) g = v;
    end
    exp_rdy = (g >= 0) ? VC_W'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("ptr", 64'(dbg_ptr), 64'(m_ptr));
    check("state", 64'(dbg_state), m_locked ? 64'(ST_LOCKED) : 64'(ST_IDLE));
    check("credit_err", 64'(credit_err), 64'(m_err));
    if (g >= 0) entry = {exp_rdy, req_addr[g*A_W +: A_W], req_data[g*D_W +: D_W], lst[g]};
    else        entry = '0;
    exp_q.push_back(entry);
    for (int v = 0; v < VC_W; v++) begin
      int sent;
      sent = (g == v) ? 1 : 0;
      if (ret[v] && sent == 0 && m_cred[v] == MAXC) m_err = 1;
      else m_cred[v] = m_cred[v] + int'(ret[v]) - sent;
    end
    if (g >= 0) begin
      if (lst[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % VC_W;
      end else begin
        m_locked = 1;
        m_lock   = g;
      end
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req_valid = '1;
    bus.credit_vc_credit_gnt = '0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check("rst_target", 64'(bus.credit_vc_target), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_ptr", 64'(dbg_ptr), 64'(0));
    check("rst_err", 64'(credit_err), 64'(0));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic run_random(input int n, input int ret_pct);
    for (int k = 0; k < n; k++) begin
      drive_cycle(VC_W'($urandom), VC_W'($urandom), ret_auto(ret_pct));
    end
  endtask

  // Monitor: one expected link state per issued cycle, popped 1 cycle later.
  initial begin
    logic [W-1:0]    e;
    logic [VC_W-1:0] et;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        et = e[W-1 -: VC_W];
        check("target", 64'(bus.credit_vc_target), 64'(et));
        if (et != '0) check("packet", 64'(bus.credit_packet), 64'(e[W-VC_W-1:0]));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    bus.credit_vc_credit_gnt = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_target", 64'(bus.credit_vc_target), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_err", 64'(credit_err), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;

    // Credit exhaustion on VC0, then a single return.
    repeat (6) drive_cycle(3'b001, 3'b001, 3'b000);
    drive_cycle(3'b001, 3'b001, 3'b001);
    repeat (3) drive_cycle(3'b001, 3'b001, 3'b000);

    // Round-robin with ample returns.
    repeat (10) drive_cycle(3'b111, 3'b111, ret_auto(100));

    // Packet lock on VC0 with a two-cycle stall while VC1 waits.
    repeat (6) drive_cycle(3'b000, 3'b000, ret_auto(100));
    drive_cycle(3'b001, 3'b000, ret_auto(100));
    drive_cycle(3'b011, 3'b000, ret_auto(100));
    repeat (2) drive_cycle(3'b010, 3'b000, ret_auto(100));
    drive_cycle(3'b011, 3'b001, ret_auto(100));
    drive_cycle(3'b011, 3'b010, ret_auto(100));

    // Over-return on a full VC1.
    repeat (6) drive_cycle(3'b000, 3'b000, ret_auto(100));
    drive_cycle(3'b000, 3'b000, 3'b010);
    drive_cycle(3'b000, 3'b000, 3'b000);

    run_random(300, 50);
    run_random(200, 15);

    // Reset in the middle of a VC0 packet.
    repeat (4) drive_cycle(3'b111, 3'b111, ret_auto(100));
    repeat (6) drive_cycle(3'b000, 3'b000, ret_auto(100));
    repeat (2) drive_cycle(3'b001, 3'b000, 3'b000);
    reset_mid();
    drive_cycle(3'b010, 3'b010, 3'b000);

    run_random(300, 60);
    drive_cycle(3'b000, 3'b000, 3'b000);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
